// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encodings, default widths and R/W bit values for the I2C slave.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package i2c_pkg;

    localparam int I2C_ADDR_SZ = 7;
    localparam int I2C_DATA_SZ = 8;

    // Value of the eighth address-frame bit.
    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    // One-hot slave states.
    typedef enum logic [6:0] {
        IDLE     = 7'b000_0001,
        ADDR     = 7'b000_0010,
        ACK_ADDR = 7'b000_0100,
        WR       = 7'b000_1000,
        ACK_WR   = 7'b001_0000,
        RD       = 7'b010_0000,
        ACK_RD   = 7'b100_0000
    } state_t;

endpackage

// File: rtl/i2c_slv_sync.sv
// i2c_slv_sync: 2-FF synchronizer plus history flop with rise/fall strobes for one bus line.
// Latency: strobe is acted on 3 CLK after the pin change; strobes last exactly one CLK.
// Backpressure: none, free-running.
module i2c_slv_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic hist;

    // Synchronize the raw line and keep one cycle of history; idle bus level is 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            hist <= 1'b1;
        end else begin
            s1   <= din;
            s2   <= s1;
            hist <= s2;
        end
    end

    assign lvl  = s2;
    assign rise = s2 & ~hist;
    assign fall = ~s2 & hist;

endmodule

// File: rtl/i2c_slave_fsm.sv
// i2c_slave_fsm: I2C slave protocol engine (address match, write bytes out, read bytes in).
// Latency: bus actions occur 3 CLK after the SCL/SDA pin edge; O_WR_VLD on the 8th data SCL rise.
// Backpressure: none by default; with I2C_SLV_CLK_STRETCH_EN, SCL is held low until I_RD_VLD.
module i2c_slave_fsm
    import i2c_pkg::*;
#(
    parameter int                 ADDR_SZ  = I2C_ADDR_SZ,
    parameter int                 DATA_SZ  = I2C_DATA_SZ,
    parameter logic [ADDR_SZ-1:0] SLV_ADDR = 7'h68
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               I_SCL,
    input  logic               I_SDA,
    output logic               O_SDA_OE,
    output logic               O_SCL_OE,
    output logic [DATA_SZ-1:0] O_DATA_WR,
    output logic               O_WR_VLD,
    output logic               O_RD_REQ,
    input  logic [DATA_SZ-1:0] I_DATA_RD,
    input  logic               I_RD_VLD,
    output logic               O_START,
    output logic               O_STOP,
    output logic               O_NACK,
    output logic               O_BUSY
);

    localparam int               CNT_W      = (DATA_SZ > 1) ? $clog2(DATA_SZ) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DATA_SZ - 1);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [DATA_SZ-1:0] sh, sh_nxt;
    logic [DATA_SZ-1:0] data_wr, data_wr_nxt;
    logic               phase, phase_nxt;
    logic               sda_oe, sda_oe_nxt;
    logic               busy, busy_nxt;
    logic               wr_vld, wr_vld_nxt;
    logic               rd_req, rd_req_nxt;
    logic               start_p, start_nxt;
    logic               stop_p, stop_nxt;
    logic               nack_p, nack_nxt;
    logic               rd_start;

    i2c_slv_sync u_scl_sync (
        .clk  (CLK),
        .rst  (RST),
        .din  (I_SCL),
        .lvl  (scl_lvl),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    i2c_slv_sync u_sda_sync (
        .clk  (CLK),
        .rst  (RST),
        .din  (I_SDA),
        .lvl  (sda_lvl),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    // START/STOP are SDA edges while SCL is high; both line copies share the same delay.
    assign start_det = scl_lvl & sda_fall;
    assign stop_det  = scl_lvl & sda_rise;

`ifdef I2C_SLV_CLK_STRETCH_EN
    logic scl_oe, scl_oe_nxt;
    logic rd_wait, rd_wait_nxt;

    // Stretch flops: SCL hold and "waiting for read data" flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scl_oe  <= 1'b0;
            rd_wait <= 1'b0;
        end else begin
            scl_oe  <= scl_oe_nxt;
            rd_wait <= rd_wait_nxt;
        end
    end

    assign O_SCL_OE = scl_oe;
`else
    logic unused_rd_vld;
    assign unused_rd_vld = I_RD_VLD;
    assign O_SCL_OE      = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and registered output pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt     <= CNT_RELOAD;
            sh      <= '0;
            data_wr <= '0;
            phase   <= 1'b0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            wr_vld  <= 1'b0;
            rd_req  <= 1'b0;
            start_p <= 1'b0;
            stop_p  <= 1'b0;
            nack_p  <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            sh      <= sh_nxt;
            data_wr <= data_wr_nxt;
            phase   <= phase_nxt;
            sda_oe  <= sda_oe_nxt;
            busy    <= busy_nxt;
            wr_vld  <= wr_vld_nxt;
            rd_req  <= rd_req_nxt;
            start_p <= start_nxt;
            stop_p  <= stop_nxt;
            nack_p  <= nack_nxt;
        end
    end

    // Next-state and datapath decode. phase marks "byte/ack bit done, act on next SCL fall".
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        sh_nxt      = sh;
        data_wr_nxt = data_wr;
        phase_nxt   = phase;
        sda_oe_nxt  = sda_oe;
        busy_nxt    = busy;
        wr_vld_nxt  = 1'b0;
        rd_req_nxt  = 1'b0;
        start_nxt   = 1'b0;
        stop_nxt    = 1'b0;
        nack_nxt    = 1'b0;
        rd_start    = 1'b0;
`ifdef I2C_SLV_CLK_STRETCH_EN
        scl_oe_nxt  = scl_oe;
        rd_wait_nxt = rd_wait;
`endif

        if (stop_det) begin
            stop_nxt   = 1'b1;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
            phase_nxt  = 1'b0;
            cnt_nxt    = CNT_RELOAD;
            state_nxt  = IDLE;
`ifdef I2C_SLV_CLK_STRETCH_EN
            scl_oe_nxt  = 1'b0;
            rd_wait_nxt = 1'b0;
`endif
        end else if (start_det) begin
            start_nxt  = 1'b1;
            sda_oe_nxt = 1'b0;
            phase_nxt  = 1'b0;
            cnt_nxt    = CNT_RELOAD;
            state_nxt  = ADDR;
`ifdef I2C_SLV_CLK_STRETCH_EN
            scl_oe_nxt  = 1'b0;
            rd_wait_nxt = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Bus ignored until the next START.
                end

                ADDR: begin
                    if (scl_rise && !phase) begin
                        sh_nxt = {sh[DATA_SZ-2:0], sda_lvl};
                        if (cnt == '0) begin
                            phase_nxt = 1'b1;
                            cnt_nxt   = CNT_RELOAD;
                        end else begin
                            cnt_nxt = cnt - 1'b1;
                        end
                    end else if (scl_fall && phase) begin
                        phase_nxt = 1'b0;
                        if (sh[DATA_SZ-1 -: ADDR_SZ] == SLV_ADDR) begin
                            sda_oe_nxt = 1'b1;
                            busy_nxt   = 1'b1;
                            state_nxt  = ACK_ADDR;
                        end else begin
                            busy_nxt  = 1'b0;
                            state_nxt = IDLE;
                        end
                    end
                end

                ACK_ADDR: begin
                    if (scl_fall) begin
                        if (sh[0] == I2C_RW_WRITE) begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = WR;
                        end else begin
                            rd_start  = 1'b1;
                            state_nxt = RD;
                        end
                    end
                end

                WR: begin
                    if (scl_rise && !phase) begin
                        sh_nxt = {sh[DATA_SZ-2:0], sda_lvl};
                        if (cnt == '0) begin
                            data_wr_nxt = {sh[DATA_SZ-2:0], sda_lvl};
                            wr_vld_nxt  = 1'b1;
                            phase_nxt   = 1'b1;
                            cnt_nxt     = CNT_RELOAD;
                        end else begin
                            cnt_nxt = cnt - 1'b1;
                        end
                    end else if (scl_fall && phase) begin
                        phase_nxt  = 1'b0;
                        sda_oe_nxt = 1'b1;
                        state_nxt  = ACK_WR;
                    end
                end

                ACK_WR: begin
                    if (scl_fall) begin
                        sda_oe_nxt = 1'b0;
                        state_nxt  = WR;
                    end
                end

                RD: begin
`ifdef I2C_SLV_CLK_STRETCH_EN
                    if (rd_wait) begin
                        if (I_RD_VLD) begin
                            sh_nxt      = I_DATA_RD;
                            sda_oe_nxt  = ~I_DATA_RD[DATA_SZ-1];
                            scl_oe_nxt  = 1'b0;
                            rd_wait_nxt = 1'b0;
                        end
                    end else
`endif
                    if (scl_fall) begin
                        if (cnt == '0) begin
                            sda_oe_nxt = 1'b0;
                            cnt_nxt    = CNT_RELOAD;
                            phase_nxt  = 1'b0;
                            state_nxt  = ACK_RD;
                        end else begin
                            cnt_nxt    = cnt - 1'b1;
                            sh_nxt     = {sh[DATA_SZ-2:0], 1'b0};
                            sda_oe_nxt = ~sh[DATA_SZ-2];
                        end
                    end
                end

                ACK_RD: begin
                    if (scl_rise) begin
                        if (sda_lvl) begin
                            nack_nxt   = 1'b1;
                            sda_oe_nxt = 1'b0;
                            busy_nxt   = 1'b0;
                            state_nxt  = IDLE;
                        end else begin
                            phase_nxt = 1'b1;
                        end
                    end else if (scl_fall && phase) begin
                        phase_nxt = 1'b0;
                        rd_start  = 1'b1;
                        state_nxt = RD;
                    end
                end

                default: begin
                    sda_oe_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                    state_nxt  = IDLE;
                end
            endcase

            // Start of a read byte: request data and put its MSB on SDA (or stretch until it arrives).
            if (rd_start) begin
                rd_req_nxt = 1'b1;
                cnt_nxt    = CNT_RELOAD;
`ifdef I2C_SLV_CLK_STRETCH_EN
                scl_oe_nxt  = 1'b1;
                rd_wait_nxt = 1'b1;
`else
                sh_nxt     = I_DATA_RD;
                sda_oe_nxt = ~I_DATA_RD[DATA_SZ-1];
`endif
            end
        end
    end

    assign O_SDA_OE  = sda_oe;
    assign O_DATA_WR = data_wr;
    assign O_WR_VLD  = wr_vld;
    assign O_RD_REQ  = rd_req;
    assign O_START   = start_p;
    assign O_STOP    = stop_p;
    assign O_NACK    = nack_p;
    assign O_BUSY    = busy;

endmodule
